// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pipe
//  Purpose  : Pipelined RV integer ALU with valid/ready handshakes, tag
//             pass-through, illegal-op flag and single-cycle flush.
//  Revision : 1.0  initial release
// ============================================================================

package drac_pkg;
    typedef enum logic [4:0] {
        ADD  = 5'd0,  SUB  = 5'd1,  SLL  = 5'd2,  SLT  = 5'd3,
        SLTU = 5'd4,  XOR  = 5'd5,  SRL  = 5'd6,  SRA  = 5'd7,
        OR   = 5'd8,  AND  = 5'd9,  ADDW = 5'd10, SUBW = 5'd11,
        SLLW = 5'd12, SRLW = 5'd13, SRAW = 5'd14, MUL  = 5'd15,
        DIV  = 5'd16, BEQ  = 5'd17, JAL  = 5'd18
    } instr_type_t;
endpackage

module alu_pipe
    import drac_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  instr_type_t       instr_type_i,
    input  logic [XLEN-1:0]   data_rs1_i,
    input  logic [XLEN-1:0]   data_rs2_i,
    input  logic [TAG_W-1:0]  tag_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [XLEN-1:0]   result_o,
    output logic [TAG_W-1:0]  tag_o,
    output logic              illegal_o
);

    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0]   shamt;
    logic [31:0]      word;
    logic [XLEN-1:0]  alu_res;
    logic             alu_ill;

    always_comb begin
        shamt   = data_rs2_i[SHW-1:0];
        word    = '0;
        alu_res = '0;
        alu_ill = 1'b0;
        case (instr_type_i)
            ADD:  alu_res = data_rs1_i + data_rs2_i;
            SUB:  alu_res = data_rs1_i - data_rs2_i;
            SLL:  alu_res = data_rs1_i << shamt;
            SLT:  alu_res = XLEN'($signed(data_rs1_i) < $signed(data_rs2_i));
            SLTU: alu_res = XLEN'(data_rs1_i < data_rs2_i);
            XOR:  alu_res = data_rs1_i ^ data_rs2_i;
            SRL:  alu_res = data_rs1_i >> shamt;
            SRA:  alu_res = $unsigned($signed(data_rs1_i) >>> shamt);
            OR:   alu_res = data_rs1_i | data_rs2_i;
            AND:  alu_res = data_rs1_i & data_rs2_i;
            ADDW, SUBW, SLLW, SRLW, SRAW: begin
                case (instr_type_i)
                    ADDW:    word = data_rs1_i[31:0] + data_rs2_i[31:0];
                    SUBW:    word = data_rs1_i[31:0] - data_rs2_i[31:0];
                    SLLW:    word = data_rs1_i[31:0] << data_rs2_i[4:0];
                    SRLW:    word = data_rs1_i[31:0] >> data_rs2_i[4:0];
                    SRAW:    word = $unsigned($signed(data_rs1_i[31:0]) >>> data_rs2_i[4:0]);
                    default: word = '0;
                endcase
                // Word ops only exist on RV64; the cast sign-extends bit 31.
                if (XLEN == 64) alu_res = XLEN'($signed(word));
                else            alu_ill = 1'b1;
            end
            default: alu_ill = 1'b1;
        endcase
    end

    logic [STAGES-1:0] slot_valid;
    logic [XLEN-1:0]   slot_result [STAGES];
    logic [TAG_W-1:0]  slot_tag    [STAGES];
    logic              slot_ill    [STAGES];

    logic [STAGES-1:0] take;
    logic [STAGES-1:0] in_valid;
    logic [XLEN-1:0]   in_result [STAGES];
    logic [TAG_W-1:0]  in_tag    [STAGES];
    logic              in_ill    [STAGES];
    logic              accept;

    // A slot can take new content when it, or any slot downstream, is free,
    // or the consumer is draining the last slot.
    always_comb begin
        logic free;
        take = '0;
        for (int k = 0; k < STAGES; k++) begin
            free = ready_i;
            for (int j = k; j < STAGES; j++) begin
                free = free | ~slot_valid[j];
            end
            take[k] = free;
        end
    end

    assign ready_o = rstn_i && !flush_i && take[0];
    assign accept  = valid_i && ready_o;

    for (genvar k = 0; k < STAGES; k++) begin : g_slot
        if (k == 0) begin : g_head
            assign in_valid[k]  = accept;
            assign in_result[k] = alu_res;
            assign in_tag[k]    = tag_i;
            assign in_ill[k]    = alu_ill;
        end else begin : g_body
            assign in_valid[k]  = slot_valid[k-1];
            assign in_result[k] = slot_result[k-1];
            assign in_tag[k]    = slot_tag[k-1];
            assign in_ill[k]    = slot_ill[k-1];
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            slot_valid <= '0;
            for (int k = 0; k < STAGES; k++) begin
                slot_result[k] <= '0;
                slot_tag[k]    <= '0;
                slot_ill[k]    <= 1'b0;
            end
        end else if (flush_i) begin
            slot_valid <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (take[k]) begin
                    slot_valid[k] <= in_valid[k];
                    if (in_valid[k]) begin
                        slot_result[k] <= in_result[k];
                        slot_tag[k]    <= in_tag[k];
                        slot_ill[k]    <= in_ill[k];
                    end
                end
            end
        end
    end

    assign valid_o   = slot_valid[STAGES-1] && !flush_i;
    assign result_o  = slot_result[STAGES-1];
    assign tag_o     = slot_tag[STAGES-1];
    assign illegal_o = slot_ill[STAGES-1];

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_pipe
//  Purpose  : Self-checking bench for alu_pipe (RV64/2-slot and RV32/1-slot).
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_pipe;
    import drac_pkg::*;

    localparam int STG = 2;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic        flush = 1'b0, vin = 1'b0, rdy_in = 1'b0;
    instr_type_t op = ADD;
    logic [63:0] rs1 = '0, rs2 = '0;
    logic [4:0]  tag = '0;
    logic        rdy_out, vout, ill;
    logic [63:0] res;
    logic [4:0]  tag_out;

    logic        vin32 = 1'b0, rdy_in32 = 1'b1, flush32 = 1'b0;
    instr_type_t op32 = ADD;
    logic [31:0] a32 = '0, b32 = '0;
    logic [4:0]  tag32 = '0;
    logic        rdy_out32, vout32, ill32;
    logic [31:0] res32;
    logic [4:0]  tag_out32;

    alu_pipe #(.XLEN(64), .STAGES(STG), .TAG_W(5)) dut (
        .clk_i(clk), .rstn_i(rstn), .flush_i(flush), .valid_i(vin), .ready_o(rdy_out),
        .instr_type_i(op), .data_rs1_i(rs1), .data_rs2_i(rs2), .tag_i(tag),
        .valid_o(vout), .ready_i(rdy_in), .result_o(res), .tag_o(tag_out), .illegal_o(ill)
    );

    alu_pipe #(.XLEN(32), .STAGES(1), .TAG_W(5)) dut32 (
        .clk_i(clk), .rstn_i(rstn), .flush_i(flush32), .valid_i(vin32), .ready_o(rdy_out32),
        .instr_type_i(op32), .data_rs1_i(a32), .data_rs2_i(b32), .tag_i(tag32),
        .valid_o(vout32), .ready_i(rdy_in32), .result_o(res32), .tag_o(tag_out32),
        .illegal_o(ill32)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference ALU: {illegal, result}, derived from the ISA rules directly.
    function automatic logic [64:0] ref_alu(instr_type_t o, logic [63:0] a, logic [63:0] b, int xlen);
        logic [63:0] mask, ua, ub, r;
        longint      sa, sb;
        int          sh;
        logic [31:0] w;
        bit          bad;
        mask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        ua   = a & mask;
        ub   = b & mask;
        sa   = (xlen == 64) ? longint'(a) : longint'({{32{a[31]}}, a[31:0]});
        sb   = (xlen == 64) ? longint'(b) : longint'({{32{b[31]}}, b[31:0]});
        sh   = int'(ub % 64'(xlen));
        bad  = 1'b0;
        r    = '0;
        w    = '0;
        case (o)
            ADD:  r = ua + ub;
            SUB:  r = ua - ub;
            SLL:  r = ua << sh;
            SLT:  r = (sa < sb) ? 64'd1 : 64'd0;
            SLTU: r = (ua < ub) ? 64'd1 : 64'd0;
            XOR:  r = ua ^ ub;
            SRL:  r = ua >> sh;
            SRA:  r = 64'(sa >>> sh);
            OR:   r = ua | ub;
            AND:  r = ua & ub;
            ADDW, SUBW, SLLW, SRLW, SRAW: begin
                if (xlen != 64) bad = 1'b1;
                else begin
                    case (o)
                        ADDW:    w = a[31:0] + b[31:0];
                        SUBW:    w = a[31:0] - b[31:0];
                        SLLW:    w = a[31:0] << b[4:0];
                        SRLW:    w = a[31:0] >> b[4:0];
                        default: w = $unsigned($signed(a[31:0]) >>> b[4:0]);
                    endcase
                    r = {{32{w[31]}}, w};
                end
            end
            default: bad = 1'b1;
        endcase
        r = r & mask;
        if (bad) r = '0;
        return {bad, r};
    endfunction

    function automatic logic [63:0] rand_operand();
        case ($urandom_range(0, 4))
            0:       return 64'hFFFF_FFFF_FFFF_FFFF;
            1:       return 64'h8000_0000_0000_0000 | 64'($urandom_range(0, 255));
            2:       return {32'h0, $urandom()};
            3:       return 64'($urandom_range(0, 70));
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    task automatic run_op(input string name, input instr_type_t o, input logic [63:0] a,
                          input logic [63:0] b, input logic [4:0] t,
                          input logic [63:0] exp_res, input logic exp_ill);
        @(negedge clk);
        flush = 1'b0; rdy_in = 1'b1; vin = 1'b1; op = o; rs1 = a; rs2 = b; tag = t;
        #1 check_eq({name, "_rdy"}, 64'(rdy_out), 64'd1);
        @(negedge clk);
        vin = 1'b0;
        #1 check_eq({name, "_early"}, 64'(vout), 64'd0);
        @(negedge clk);
        #1;
        check_eq({name, "_valid"}, 64'(vout), 64'd1);
        check_eq({name, "_res"}, res, exp_res);
        check_eq({name, "_tag"}, 64'(tag_out), 64'(t));
        check_eq({name, "_ill"}, 64'(ill), 64'(exp_ill));
    endtask

    task automatic run_op32(input string name, input instr_type_t o, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] t,
                            input logic [31:0] exp_res, input logic exp_ill);
        @(negedge clk);
        vin32 = 1'b1; op32 = o; a32 = a; b32 = b; tag32 = t;
        #1 check_eq({name, "_rdy"}, 64'(rdy_out32), 64'd1);
        @(negedge clk);
        vin32 = 1'b0;
        #1;
        check_eq({name, "_valid"}, 64'(vout32), 64'd1);
        check_eq({name, "_res"}, 64'(res32), 64'(exp_res));
        check_eq({name, "_tag"}, 64'(tag_out32), 64'(t));
        check_eq({name, "_ill"}, 64'(ill32), 64'(exp_ill));
    endtask

    typedef struct packed {
        logic [4:0]  t;
        logic        il;
        logic [63:0] r;
    } exp_t;

    instr_type_t legal_ops [15] = '{ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
                                    ADDW, SUBW, SLLW, SRLW, SRAW};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t        q[$];
        exp_t        e;
        logic [64:0] m;
        logic [4:0]  got[$];
        int          next_tag;
        bit          do_flush;

        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_valid", 64'(vout), 64'd0);
        check_eq("rst_res", res, 64'd0);
        check_eq("rst_tag", 64'(tag_out), 64'd0);
        check_eq("rst_ill", 64'(ill), 64'd0);
        check_eq("rst_rdy", 64'(rdy_out), 64'd0);
        check_eq("rst_rdy32", 64'(rdy_out32), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        #1 check_eq("post_rst_rdy", 64'(rdy_out), 64'd1);

        run_op("add_wrap", ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd3, 64'd0, 1'b0);
        run_op("addw", ADDW, 64'h7FFF_FFFF, 64'd1, 5'd4, 64'hFFFF_FFFF_8000_0000, 1'b0);
        run_op("sraw", SRAW, 64'h8000_0000, 64'd4, 5'd5, 64'hFFFF_FFFF_F800_0000, 1'b0);
        run_op("slt", SLT, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd6, 64'd1, 1'b0);
        run_op("sltu", SLTU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd7, 64'd0, 1'b0);
        run_op("illegal", instr_type_t'(5'd20), 64'd5, 64'd6, 5'd8, 64'd0, 1'b1);

        run_op32("subw32", SUBW, 32'd9, 32'd3, 5'd1, 32'd0, 1'b1);
        run_op32("sll32", SLL, 32'd1, 32'h21, 5'd2, 32'd2, 1'b0);
        run_op32("add32", ADD, 32'hFFFF_FFFF, 32'd2, 5'd3, 32'd1, 1'b0);

        // Back-pressure: only STG ops fit while the consumer is stalled.
        next_tag = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            rdy_in = 1'b0; vin = 1'b1; op = ADD;
            rs1 = 64'(next_tag); rs2 = 64'd100; tag = 5'(next_tag);
            #1 if (rdy_out) next_tag++;
        end
        @(negedge clk);
        #1;
        check_eq("bp_accepts", 64'(next_tag), 64'(STG));
        check_eq("bp_rdy_low", 64'(rdy_out), 64'd0);
        check_eq("bp_valid", 64'(vout), 64'd1);
        check_eq("bp_hold_tag", 64'(tag_out), 64'd0);
        check_eq("bp_hold_res", res, 64'd100);
        got.delete();
        for (int c = 0; c < 30 && got.size() < 6; c++) begin
            @(negedge clk);
            rdy_in = 1'b1;
            vin = (next_tag < 6);
            rs1 = 64'(next_tag); rs2 = 64'd100; tag = 5'(next_tag);
            #1;
            if (c == 0) check_eq("bp_release_rdy", 64'(rdy_out), 64'd1);
            if (vout && rdy_in) begin
                check_eq("bp_order_tag", 64'(tag_out), 64'(got.size()));
                check_eq("bp_order_res", res, 64'(got.size()) + 64'd100);
                got.push_back(tag_out);
            end
            if (vin && rdy_out) next_tag++;
        end
        vin = 1'b0;
        check_eq("bp_count", 64'(got.size()), 64'd6);

        // Flush with the pipe full and a third op waiting.
        @(negedge clk);
        rdy_in = 1'b0; vin = 1'b1; op = ADD; rs1 = 64'd1; rs2 = 64'd1; tag = 5'd10;
        #1 check_eq("fl_acc0", 64'(rdy_out), 64'd1);
        @(negedge clk);
        tag = 5'd11;
        #1 check_eq("fl_acc1", 64'(rdy_out), 64'd1);
        @(negedge clk);
        tag = 5'd12; flush = 1'b1;
        #1;
        check_eq("fl_valid", 64'(vout), 64'd0);
        check_eq("fl_rdy", 64'(rdy_out), 64'd0);
        @(negedge clk);
        flush = 1'b0; vin = 1'b0;
        #1;
        check_eq("fl_after_valid", 64'(vout), 64'd0);
        check_eq("fl_after_rdy", 64'(rdy_out), 64'd1);
        rdy_in = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1 check_eq("fl_stale", 64'(vout), 64'd0);
        end
        run_op("post_flush", XOR, 64'hF0F0, 64'h0FF0, 5'd13, 64'hFF00, 1'b0);

        // Asynchronous reset in the middle of a cycle with ops in flight.
        @(negedge clk);
        rdy_in = 1'b0; vin = 1'b1; op = OR; rs1 = 64'hF0; rs2 = 64'h0F; tag = 5'd20;
        @(negedge clk);
        tag = 5'd21;
        @(negedge clk);
        vin = 1'b0;
        #1 check_eq("ar_pre_valid", 64'(vout), 64'd1);
        #2 rstn = 1'b0;
        #1;
        check_eq("ar_valid", 64'(vout), 64'd0);
        check_eq("ar_res", res, 64'd0);
        check_eq("ar_tag", 64'(tag_out), 64'd0);
        check_eq("ar_rdy", 64'(rdy_out), 64'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1; rdy_in = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1 check_eq("ar_stale", 64'(vout), 64'd0);
        end

        // Randomized traffic against the reference model.
        q.delete();
        for (int c = 0; c < 600; c++) begin
            int idx;
            @(negedge clk);
            do_flush = ($urandom_range(0, 39) == 0);
            flush  = do_flush;
            vin    = ($urandom_range(0, 9) < 7);
            rdy_in = ($urandom_range(0, 9) < 6);
            idx    = $urandom_range(0, 15);
            op     = (idx == 15) ? instr_type_t'(5'($urandom_range(15, 31))) : legal_ops[idx];
            rs1    = rand_operand();
            rs2    = rand_operand();
            tag    = 5'(c);
            #1;
            if (do_flush) begin
                check_eq("rnd_flush_valid", 64'(vout), 64'd0);
                check_eq("rnd_flush_rdy", 64'(rdy_out), 64'd0);
                q.delete();
            end else begin
                check_eq("rnd_rdy", 64'(rdy_out), 64'((q.size() < STG) || rdy_in));
                if (vout && q.size() == 0) check_eq("rnd_spurious", 64'(vout), 64'd0);
                if (vout && rdy_in && q.size() > 0) begin
                    e = q.pop_front();
                    check_eq("rnd_tag", 64'(tag_out), 64'(e.t));
                    check_eq("rnd_res", res, e.r);
                    check_eq("rnd_ill", 64'(ill), 64'(e.il));
                end
                if (vin && rdy_out) begin
                    m = ref_alu(op, rs1, rs2, 64);
                    q.push_back('{t: tag, il: m[64], r: m[63:0]});
                end
            end
        end
        @(negedge clk);
        flush = 1'b0; vin = 1'b0; rdy_in = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (vout && q.size() > 0) begin
                e = q.pop_front();
                check_eq("drain_tag", 64'(tag_out), 64'(e.t));
                check_eq("drain_res", res, e.r);
            end
            @(negedge clk);
        end
        check_eq("drain_empty", 64'(q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, pipelined successor to the single-cycle integer ALU in the Drac execute stage. It accepts one RV integer ALU operation per cycle over a valid/ready handshake and computes it in the input cycle. The result travels through `STAGES` register slots together with a tag, and the block raises an illegal-op flag where needed. It sits between the issue logic and writeback. It supports back-pressure and a single-cycle pipeline flush on branch mispredict or exception.

## Interface

Parameters:
- `XLEN`, 64: datapath width. Legal values are 32 and 64.
- `STAGES`, 2: number of register slots between input and output. Legal range is 1..4.
- `TAG_W`, 5: width of the destination/ROB tag carried alongside each operation.

Ports:
- `clk_i` input, 1: clock. All state updates on the rising edge.
- `rstn_i` input, 1: reset, asynchronous and active-low.
- `flush_i` input, 1: kill all in-flight operations.
- `valid_i` input, 1: an operation is presented on the input.
- `ready_o` output, 1: the block can accept the presented operation this cycle.
- `instr_type_i` input, `instr_type_t`: operation select (`drac_pkg`).
- `data_rs1_i` input, `XLEN`: operand 1.
- `data_rs2_i` input, `XLEN`: operand 2.
- `tag_i` input, `TAG_W`: tag for the operation.
- `valid_o` output, 1: a result is presented on the output.
- `ready_i` input, 1: the consumer accepts the result this cycle.
- `result_o` output, `XLEN`: result.
- `tag_o` output, `TAG_W`: tag of the result.
- `illegal_o` output, 1: the operation was unsupported; `result_o` is 0.

## Operation

- Input handshake: an operation is accepted on a rising edge when `valid_i && ready_o`. Output handshake: a result transfers when `valid_o && ready_i`.
- Compute happens combinationally on the accepted inputs, in the acceptance cycle.
- Slot 0 captures `{valid, result, tag, illegal}`. Slot k advances to slot k+1 when slot k+1 is empty or is itself advancing. The last slot drains when `ready_i` is high.
- `ready_o = rstn_i && !flush_i && (!slot0.valid || slot0 advances)`.
- `valid_o = last.valid && !flush_i`. `result_o`, `tag_o` and `illegal_o` are driven from the last slot.
- Ops: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND operate at full `XLEN`.
- Shift amount is `data_rs2_i[$clog2(XLEN)-1:0]`.
- SLT is a signed compare; SLTU is unsigned. The result is `{(XLEN-1)'b0, cmp}`.
- SRA is an arithmetic shift; SRL is a logical shift.
- ADD and SUB wrap modulo 2^XLEN.
- W ops (ADDW, SUBW, SLLW, SRLW, SRAW) are legal only when `XLEN == 64`:
  - They operate on bits [31:0], using a shift amount of `rs2[4:0]`.
  - The 32-bit result is sign-extended from bit 31 into bits [63:32].
  - SRAW shifts the signed low word.
- With `XLEN == 32`, W ops are illegal.
- Any other `instr_type_i` value is illegal.
- An illegal op produces `result_o = 0` and `illegal_o = 1`. It still occupies a slot and completes normally with its tag.
- Flush: while `flush_i` is high, no input is accepted and `valid_o` is forced to 0. At that edge all slot valid bits clear. Data and tag registers need not clear. The cycle after flush deasserts, the block is empty and `ready_o = 1`.
- Flush takes priority over every simultaneous input or output handshake.
- Stall: while `valid_o && !ready_i`, `result_o`, `tag_o` and `illegal_o` hold stable. No slot content is overwritten or lost; a bubble upstream is absorbed.

## Timing

- Reset (`rstn_i` low, asynchronous): all slot valid bits clear and all slot data/tag/illegal registers are 0. Outputs are `valid_o = 0`, `result_o = 0`, `tag_o = 0`, `illegal_o = 0`, `ready_o = 0`.
- First cycle after reset release: `ready_o = 1`.
- Latency: an op accepted at edge N appears with `valid_o = 1` in the cycle after edge N+STAGES-1, provided `ready_i` stays high. With `STAGES = 1` it is visible the cycle after acceptance.
- Throughput: one op per cycle when `ready_i` is held high. Full-rate streaming has no bubbles.
- Capacity: at most `STAGES` ops in flight. When all slots are full and `ready_i = 0`, `ready_o = 0` in the same cycle.
- Release from full: `ready_i` rising makes `ready_o` rise in the same cycle. This is a combinational ready chain; the path from `ready_i` to `ready_o` is allowed.
- Reset asserted mid-operation: all in-flight ops are discarded immediately and outputs take their reset values. No partial result appears.

## Test plan

- Reset, `STAGES = 2`, `XLEN = 64`, `ready_i = 1`. Send ADD with rs1 `0xFFFF_FFFF_FFFF_FFFF`, rs2 1, tag 3 -> two cycles later `valid_o = 1`, `result_o = 0`, `tag_o = 3`, `illegal_o = 0`.
- ADDW with rs1 `0x7FFF_FFFF`, rs2 1 -> `0xFFFF_FFFF_8000_0000`. SRAW with rs1 `0x8000_0000`, rs2 4 -> `0xFFFF_FFFF_F800_0000`. SLT with -1 and 1 -> 1; SLTU with the same operands -> 0.
- `XLEN = 32` build. SUBW -> `illegal_o = 1`, `result_o = 0`. SLL with rs2 `0x21` -> shifts by 1 (5-bit amount).
- Back-pressure: stream 6 ops with tags 0..5 while holding `ready_i = 0` -> `ready_o` drops after 2 accepts and `result_o` holds tag 0. Then assert `ready_i` -> tags 0..5 emerge in order, with no loss or duplication.
- Flush with 2 ops in flight, a third presented and `ready_i = 0` -> no output that cycle, third op not accepted. Next cycle `valid_o = 0` and `ready_o = 1`. A later op then completes with latency `STAGES`.
- Assert `rstn_i` low asynchronously, mid-cycle, with ops in flight -> `valid_o` and `result_o` go to 0 immediately. After release no stale result appears.
